// File: rtl/qft_pulse_sched_pkg.sv
// rtl/qft_pulse_sched_pkg.sv - shared types and Q1.15 constants for the QFT pulse scheduler
package qft_pulse_sched_pkg;

    localparam int AMP_W = 17;
    localparam int IDX_W = 3;

    localparam logic [AMP_W-1:0] Q_ONE  = 17'h08000;
    localparam logic [AMP_W-1:0] Q_HALF = 17'h04000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CALC,
        S_GAP,
        S_PULSE,
        S_TAIL
    } fsm_t;

endpackage

// File: rtl/qft_pulse_sched_prob_calc.sv
// rtl/qft_pulse_sched_prob_calc.sv - combinational |amp|^2 in Q1.15, saturated to 1.0
module prob_calc
    import qft_pulse_sched_pkg::*;
(
    input  logic signed [AMP_W-1:0] re,
    input  logic signed [AMP_W-1:0] im,
    output logic        [AMP_W-1:0] p
);

    logic signed [2*AMP_W-1:0] re_sq;
    logic signed [2*AMP_W-1:0] im_sq;
    logic signed [2*AMP_W-1:0] sum;

    always_comb begin
        re_sq = re * re;
        im_sq = im * im;
        sum   = (re_sq >>> 15) + (im_sq >>> 15);
        // Rounding can push |re|^2+|im|^2 past 1.0; clamp so widths never exceed full scale
        if (sum > $signed(34'(Q_ONE)))
            p = Q_ONE;
        else
            p = sum[AMP_W-1:0];
    end

endmodule

// File: rtl/qft_pulse_sched.sv
// rtl/qft_pulse_sched.sv - fetches 8 QFT amplitudes and plays their probabilities as pulse widths on sq
module qft_pulse_sched
    import qft_pulse_sched_pkg::*;
#(
    parameter int unsigned GAP_CYC     = 5_500_000,
    parameter int unsigned WIDTH_MUL   = 2_500_000,
    parameter int unsigned WIDTH_SHIFT = 11,
    parameter int unsigned TAIL_GAPS   = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    loop,
    output logic                    amp_req,
    output logic [IDX_W-1:0]        amp_idx,
    input  logic                    amp_ack,
    input  logic signed [AMP_W-1:0] amp_re,
    input  logic signed [AMP_W-1:0] amp_im,
    output logic                    sq,
    output logic [3:0]              state,
    output logic                    busy,
    output logic                    done
);

    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [31:0] TAIL_LEN  = 32'(TAIL_GAPS * GAP_CYC);
    localparam logic [31:0] TAIL_LAST = TAIL_LEN - 32'd1;
    localparam logic [31:0] TAIL_PRE  = TAIL_LEN - 32'd2;

    fsm_t                    fsm;
    logic [IDX_W-1:0]        idx;
    logic [31:0]             cnt;
    logic signed [AMP_W-1:0] re_q;
    logic signed [AMP_W-1:0] im_q;
    logic [31:0]             width [8];

    logic [AMP_W-1:0]        p;
    logic [31:0]             w_new;
    logic [31:0]             cur_w;
    logic                    step;

    prob_calc u_prob (
        .re (re_q),
        .im (im_q),
        .p  (p)
    );

    always_comb begin
        w_new = 32'((48'(WIDTH_MUL) * 48'(p)) >> WIDTH_SHIFT);
        cur_w = width[idx];
        // A slot is finished when its pulse ends, or when its gap ends and the pulse is empty
        step  = ((fsm == S_GAP) && (cnt == GAP_LAST) && (cur_w == 32'd0)) ||
                ((fsm == S_PULSE) && (cnt == cur_w - 32'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            re_q    <= '0;
            im_q    <= '0;
            amp_req <= 1'b0;
            amp_idx <= '0;
            sq      <= 1'b0;
            state   <= 4'd8;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 8; i++) width[i] <= '0;
        end else begin
            done <= 1'b0;
            cnt  <= cnt + 32'd1;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        fsm     <= S_FETCH;
                        idx     <= '0;
                        cnt     <= '0;
                        amp_req <= 1'b1;
                        amp_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (amp_ack) begin
                        re_q    <= amp_re;
                        im_q    <= amp_im;
                        amp_req <= 1'b0;
                        fsm     <= S_CALC;
                        cnt     <= '0;
                    end
                end
                S_CALC: begin
                    width[idx] <= w_new;
                    cnt        <= '0;
                    if (idx != 3'd7) begin
                        idx     <= idx + 3'd1;
                        amp_idx <= idx + 3'd1;
                        amp_req <= 1'b1;
                        fsm     <= S_FETCH;
                    end else begin
                        idx   <= '0;
                        state <= 4'd0;
                        fsm   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST && cur_w != 32'd0) begin
                        cnt <= '0;
                        sq  <= 1'b1;
                        fsm <= S_PULSE;
                    end
                end
                S_PULSE: ;
                S_TAIL: begin
                    if (cnt == TAIL_PRE) done <= 1'b1;
                    if (cnt == TAIL_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (loop) begin
                            fsm     <= S_FETCH;
                            amp_req <= 1'b1;
                            amp_idx <= '0;
                        end else begin
                            fsm  <= S_IDLE;
                            busy <= 1'b0;
                        end
                    end
                end
                default: fsm <= S_IDLE;
            endcase

            if (step) begin
                cnt <= '0;
                sq  <= 1'b0;
                if (idx != 3'd7) begin
                    idx   <= idx + 3'd1;
                    state <= {1'b0, idx + 3'd1};
                    fsm   <= S_GAP;
                end else begin
                    idx   <= '0;
                    state <= 4'd8;
                    fsm   <= S_TAIL;
                    if (TAIL_LEN == 32'd1) done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qft_pulse_sched.sv
// tb/tb_qft_pulse_sched.sv - directed self-checking bench for qft_pulse_sched
module tb_qft_pulse_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        loop;
    logic        amp_req;
    logic [2:0]  amp_idx;
    logic        amp_ack;
    logic [16:0] amp_re;
    logic [16:0] amp_im;
    logic        sq;
    logic [3:0]  state;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [16:0] tre [8];
    logic [16:0] tim [8];
    int          dly [8];
    int          wcnt = 0;

    int          n_pulses;
    int          p_start [8];
    int          p_len   [8];
    logic [3:0]  p_state [8];
    bit          st_bad;
    int          done_cyc;
    int          req3_len;

    always #5 clk = ~clk;

    qft_pulse_sched #(
        .GAP_CYC     (4),
        .WIDTH_MUL   (1),
        .WIDTH_SHIFT (12),
        .TAIL_GAPS   (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .loop    (loop),
        .amp_req (amp_req),
        .amp_idx (amp_idx),
        .amp_ack (amp_ack),
        .amp_re  (amp_re),
        .amp_im  (amp_im),
        .sq      (sq),
        .state   (state),
        .busy    (busy),
        .done    (done)
    );

    // Amplitude source: acks dly[idx] cycles after the request is first seen
    always @(negedge clk) begin
        if (amp_req && !amp_ack) begin
            if (wcnt >= dly[amp_idx]) begin
                amp_ack = 1'b1;
                amp_re  = tre[amp_idx];
                amp_im  = tim[amp_idx];
            end else begin
                wcnt++;
            end
        end else begin
            amp_ack = 1'b0;
            amp_re  = '0;
            amp_im  = '0;
            wcnt    = 0;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            tre[i] = '0;
            tim[i] = '0;
            dly[i] = 1;
        end
    endtask

    task automatic capture(input bit do_start, input bit hold_start, input int max_cyc);
        logic prev;
        prev     = 1'b0;
        n_pulses = 0;
        done_cyc = -1;
        req3_len = 0;
        st_bad   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p_start[i] = -1;
            p_len[i]   = 0;
            p_state[i] = 4'hf;
        end
        if (do_start) start = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (sq && !prev) begin
                if (n_pulses < 8) begin
                    p_start[n_pulses] = c;
                    p_state[n_pulses] = state;
                end
                n_pulses++;
            end
            if (sq && n_pulses > 0 && n_pulses <= 8) begin
                p_len[n_pulses-1]++;
                if (state != p_state[n_pulses-1]) st_bad = 1'b1;
            end
            if (amp_req && amp_idx == 3'd3) req3_len++;
            prev = sq;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sq !== 1'b0)      begin errors++; $display("FAIL reset_sq: got %b expected 0", sq); end
        checks++; if (amp_req !== 1'b0) begin errors++; $display("FAIL reset_amp_req: got %b expected 0", amp_req); end
        checks++; if (amp_idx !== 3'd0) begin errors++; $display("FAIL reset_amp_idx: got %0d expected 0", amp_idx); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (state !== 4'd8)   begin errors++; $display("FAIL reset_state: got %0d expected 8", state); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basis0();
        clear_table();
        tre[0] = 17'h08000;
        capture(1'b1, 1'b0, 200);
        checks++; if (n_pulses !== 1)      begin errors++; $display("FAIL basis0_npulses: got %0d expected 1", n_pulses); end
        checks++; if (p_start[0] !== 28)   begin errors++; $display("FAIL basis0_rise: got %0d expected 28", p_start[0]); end
        checks++; if (p_len[0] !== 8)      begin errors++; $display("FAIL basis0_width: got %0d expected 8", p_len[0]); end
        checks++; if (p_state[0] !== 4'd0) begin errors++; $display("FAIL basis0_state: got %0d expected 0", p_state[0]); end
        checks++; if (st_bad !== 1'b0)     begin errors++; $display("FAIL basis0_state_stable: got %b expected 0", st_bad); end
        checks++; if (done_cyc !== 71)     begin errors++; $display("FAIL basis0_done: got %0d expected 71", done_cyc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL basis0_idle_busy: got %b expected 0", busy); end
        checks++; if (state !== 4'd8)      begin errors++; $display("FAIL basis0_idle_state: got %0d expected 8", state); end
    endtask

    task automatic test_half();
        clear_table();
        tre[0] = 17'h05A82;
        tre[1] = 17'h05A82;
        capture(1'b1, 1'b0, 200);
        checks++; if (n_pulses !== 2)      begin errors++; $display("FAIL half_npulses: got %0d expected 2", n_pulses); end
        checks++; if (p_start[0] !== 28)   begin errors++; $display("FAIL half_rise0: got %0d expected 28", p_start[0]); end
        checks++; if (p_len[0] !== 3)      begin errors++; $display("FAIL half_width0: got %0d expected 3", p_len[0]); end
        checks++; if (p_start[1] !== 35)   begin errors++; $display("FAIL half_rise1: got %0d expected 35", p_start[1]); end
        checks++; if (p_len[1] !== 3)      begin errors++; $display("FAIL half_width1: got %0d expected 3", p_len[1]); end
        checks++; if (p_state[1] !== 4'd1) begin errors++; $display("FAIL half_state1: got %0d expected 1", p_state[1]); end
        checks++; if (done_cyc !== 69)     begin errors++; $display("FAIL half_done: got %0d expected 69", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_ack_delay();
        clear_table();
        tim[3] = 17'h08000;
        dly[3] = 5;
        capture(1'b1, 1'b0, 200);
        checks++; if (req3_len !== 6)      begin errors++; $display("FAIL ackdly_req_hold: got %0d expected 6", req3_len); end
        checks++; if (n_pulses !== 1)      begin errors++; $display("FAIL ackdly_npulses: got %0d expected 1", n_pulses); end
        checks++; if (p_start[0] !== 44)   begin errors++; $display("FAIL ackdly_rise: got %0d expected 44", p_start[0]); end
        checks++; if (p_len[0] !== 8)      begin errors++; $display("FAIL ackdly_width: got %0d expected 8", p_len[0]); end
        checks++; if (p_state[0] !== 4'd3) begin errors++; $display("FAIL ackdly_state: got %0d expected 3", p_state[0]); end
        checks++; if (done_cyc !== 75)     begin errors++; $display("FAIL ackdly_done: got %0d expected 75", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        clear_table();
        tre[0] = 17'h08000;
        tim[0] = 17'h08000;
        tre[5] = 17'h18000;
        tim[5] = 17'h18000;
        capture(1'b1, 1'b0, 200);
        checks++; if (n_pulses !== 2)      begin errors++; $display("FAIL sat_npulses: got %0d expected 2", n_pulses); end
        checks++; if (p_len[0] !== 8)      begin errors++; $display("FAIL sat_width0: got %0d expected 8", p_len[0]); end
        checks++; if (p_start[1] !== 56)   begin errors++; $display("FAIL sat_rise5: got %0d expected 56", p_start[1]); end
        checks++; if (p_len[1] !== 8)      begin errors++; $display("FAIL sat_width5: got %0d expected 8", p_len[1]); end
        checks++; if (p_state[1] !== 4'd5) begin errors++; $display("FAIL sat_state5: got %0d expected 5", p_state[1]); end
        checks++; if (done_cyc !== 79)     begin errors++; $display("FAIL sat_done: got %0d expected 79", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        clear_table();
        tre[0] = 17'h08000;
        capture(1'b1, 1'b1, 200);
        checks++; if (n_pulses !== 1)      begin errors++; $display("FAIL busystart_npulses: got %0d expected 1", n_pulses); end
        checks++; if (p_start[0] !== 28)   begin errors++; $display("FAIL busystart_rise: got %0d expected 28", p_start[0]); end
        checks++; if (done_cyc !== 71)     begin errors++; $display("FAIL busystart_done: got %0d expected 71", done_cyc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL busystart_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        clear_table();
        tre[0] = 17'h08000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sq !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (sq !== 1'b1)  begin errors++; $display("FAIL rstmid_reach_pulse: got %b expected 1", sq); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sq !== 1'b0)    begin errors++; $display("FAIL rstmid_sq: got %b expected 0", sq); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (state !== 4'd8) begin errors++; $display("FAIL rstmid_state: got %0d expected 8", state); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_stay_idle: got %b expected 0", busy); end
        checks++; if (amp_req !== 1'b0) begin errors++; $display("FAIL rstmid_no_req: got %b expected 0", amp_req); end
    endtask

    task automatic test_loop();
        clear_table();
        tre[0] = 17'h08000;
        loop = 1'b1;
        capture(1'b1, 1'b0, 200);
        checks++; if (done_cyc !== 71)  begin errors++; $display("FAIL loop_done1: got %0d expected 71", done_cyc); end
        @(negedge clk);
        checks++; if (amp_req !== 1'b1) begin errors++; $display("FAIL loop_req_after_done: got %b expected 1", amp_req); end
        checks++; if (amp_idx !== 3'd0) begin errors++; $display("FAIL loop_idx_after_done: got %0d expected 0", amp_idx); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL loop_busy: got %b expected 1", busy); end
        loop = 1'b0;
        capture(1'b0, 1'b0, 200);
        checks++; if (p_start[0] !== 27) begin errors++; $display("FAIL loop_rise2: got %0d expected 27", p_start[0]); end
        checks++; if (p_len[0] !== 8)    begin errors++; $display("FAIL loop_width2: got %0d expected 8", p_len[0]); end
        checks++; if (done_cyc !== 70)   begin errors++; $display("FAIL loop_done2: got %0d expected 70", done_cyc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL loop_end_idle: got %b expected 0", busy); end
    endtask

    initial begin
        start   = 1'b0;
        loop    = 1'b0;
        amp_ack = 1'b0;
        amp_re  = '0;
        amp_im  = '0;
        clear_table();
        test_reset();
        test_basis0();
        test_half();
        test_ack_delay();
        test_saturate();
        test_busy_start();
        test_reset_mid_pulse();
        test_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
